jam_search: RTL and testbench
=============================

# jam_search

Parametrised job-assignment search engine: for an N×N cost matrix it enumerates all N! worker-to-job permutations in lexicographic order, fetches each cost over a W/J index interface, and reports the minimum total cost and how many permutations reach it. It is the generalised successor to the fixed 8×8 assignment core. It adds a selectable matrix size, parametrised widths, a START/BUSY handshake for back-to-back runs, saturating match counting, and optional branch-and-bound pruning.

## Interface
- N, 8: matrix dimension (workers = jobs), legal 2..8
- CW, 7: width of one cost entry
- MCW, 16: MatchCount width; counter saturates at 2^MCW-1
- derived IW = max(1, clog2(N)); SW = CW + clog2(N) (sum width)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  begin a search; sampled in IDLE or DONE only
- W  out  IW  worker index of requested cost
- J  out  IW  job index of requested cost
- Cost  in  CW  cost of (W,J); combinationally valid in the same cycle W/J are driven
- BUSY  out  1  high in SCAN and NEXT
- MatchCount  out  MCW  number of permutations with total == MinCost
- MinCost  out  SW  minimum total cost found
- Valid  out  1  results final

## Operation
- States: IDLE, SCAN, NEXT, DONE.
- IDLE: all outputs 0. START=1 → SCAN. Permutation register loads identity 0..N-1, k=0, sum=0, min_valid=0.
- SCAN: drive W=k, J=perm[k]; sum += Cost at the clock edge. On k==N-1 → NEXT, otherwise k++.
- NEXT, single cycle:
  - if !min_valid or sum<MinCost: MinCost=sum, MatchCount=1, min_valid=1
  - else if sum==MinCost: MatchCount = sat(MatchCount+1)
  - if perm is descending (N-1..0) → DONE
  - else compute next lexicographic permutation combinationally (pivot search, swap, suffix reverse), k=0, sum=0 → SCAN
- DONE: Valid=1. MinCost and MatchCount hold. W/J=0. START=1 → clear results, SCAN (same as IDLE start).
- START in SCAN/NEXT: ignored.
- Arithmetic: sum is SW bits, no overflow possible. MinCost compare is unsigned.
- Reset mid-operation: immediate return to IDLE with all registers cleared. The run is lost.

## Timing
- Reset values: W=0, J=0, BUSY=0, MatchCount=0, MinCost=0, Valid=0.
- START sampled high at edge t → BUSY high from t+1. The first W/J presented at t+1.
- Unpruned run: N·(N+1) cycles per... exactly N!·(N+1) cycles from first SCAN to DONE. Valid rises on the edge after the final NEXT.
- Valid stays high until START or reset. It drops on the edge that samples START.
- MinCost/MatchCount may change during a run. They are meaningful only while Valid=1.

## Configuration
- JAM_PRUNE_EN defined:
  - In SCAN, if min_valid and (sum + Cost) > MinCost, abandon the permutation: go to NEXT without compare, MinCost and MatchCount unchanged.
  - Equality does not prune.
  - Results are identical to the unpruned run. Cycle count is ≤ the unpruned count.
- JAM_PRUNE_EN undefined: every permutation is scanned for all N cycles. Cycle count is exactly N!·(N+1).

## Test plan
- N=4, Cost=0 for all entries → MinCost=0, MatchCount=24, Valid after 120 BUSY cycles (pruning off).
- N=4, Cost=(W==J)?0:5 → MinCost=0, MatchCount=1. With JAM_PRUNE_EN, BUSY cycles <120 and identical results.
- N=4, Cost=W+J → every sum = 12. MinCost=12, MatchCount=24.
- N=8, Cost=127 everywhere, MCW=16 → MinCost=1016, MatchCount=40320. Rerun with MCW=4 → MatchCount=15 (saturated).
- Pulse RST low mid-SCAN, then START → all outputs 0 after reset, and the second run matches a clean run bit-for-bit.
- START held high during SCAN and again in DONE → no restart mid-run. Valid drops one edge after START in DONE and a new run completes with the same results.

Source files
------------

// File: rtl/jam_search.sv
// jam_search: exhaustive job-assignment search over an N x N cost matrix.
// Walks every worker-to-job permutation in lexicographic order, fetching one
// cost per cycle over the W/J index port, and reports the minimum total cost
// plus how many permutations reach it (saturating count).
//
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-low reset
//   START         begin a search (sampled in IDLE or DONE only)
//   W, J          worker / job index of the requested cost
//   Cost          cost of (W,J), combinationally valid while W/J are driven
//   BUSY          high while scanning
//   MatchCount    permutations whose total equals MinCost
//   MinCost       minimum total cost
//   Valid         results are final
//
// Optional feature: define JAM_PRUNE_EN to abandon a permutation as soon as
// its partial sum already exceeds the best total found so far.
module jam_search #(
  parameter int unsigned N   = 8,
  parameter int unsigned CW  = 7,
  parameter int unsigned MCW = 16,
  localparam int unsigned IW = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int unsigned SW = CW + $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  input  logic [CW-1:0]  Cost,
  output logic           BUSY,
  output logic [MCW-1:0] MatchCount,
  output logic [SW-1:0]  MinCost,
  output logic           Valid
);

  typedef enum logic [1:0] {IDLE, SCAN, NEXT, DONE} state_t;

  state_t                state, state_n;
  logic [N-1:0][IW-1:0]  perm, perm_n, perm_adv, swapped, ident;
  logic [IW-1:0]         k, k_n, piv, succ;
  logic [SW-1:0]         sum, sum_n, sum_add, min_n;
  logic [MCW-1:0]        cnt_n;
  logic                  min_valid, min_valid_n, pruned, pruned_n;
  logic                  last_perm, prune_hit;

  // Next lexicographic permutation: pivot search, swap with successor, reverse suffix.
  always_comb begin
    last_perm = 1'b1;
    piv       = '0;
    succ      = '0;
    for (int i = 0; i < N; i++) ident[i] = IW'(i);
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        last_perm = 1'b0;
        piv       = IW'(i);
      end
    end
    for (int j = 0; j < N; j++) begin
      if ((IW'(j) > piv) && (perm[j] > perm[piv])) succ = IW'(j);
    end
    swapped       = perm;
    swapped[piv]  = perm[succ];
    swapped[succ] = perm[piv];
    perm_adv      = swapped;
    // Suffix piv+1..N-1 is descending after the swap; mirror it. Index wraps modulo 2^IW harmlessly.
    for (int i = 0; i < N; i++) begin
      if (IW'(i) > piv) perm_adv[i] = swapped[piv + IW'(N) - IW'(i)];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    perm_n      = perm;
    k_n         = k;
    sum_n       = sum;
    min_n       = MinCost;
    cnt_n       = MatchCount;
    min_valid_n = min_valid;
    pruned_n    = pruned;
    sum_add     = sum + SW'(Cost);
`ifdef JAM_PRUNE_EN
    prune_hit   = min_valid && (sum_add > MinCost);
`else
    prune_hit   = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (START) begin
          state_n     = SCAN;
          perm_n      = ident;
          k_n         = '0;
          sum_n       = '0;
          min_n       = '0;
          cnt_n       = '0;
          min_valid_n = 1'b0;
          pruned_n    = 1'b0;
        end
      end
      SCAN: begin
        sum_n = sum_add;
        if (prune_hit) begin
          pruned_n = 1'b1;
          state_n  = NEXT;
        end else if (k == IW'(N - 1)) begin
          state_n = NEXT;
        end else begin
          k_n = k + IW'(1);
        end
      end
      NEXT: begin
        if (!pruned) begin
          if (!min_valid || (sum < MinCost)) begin
            min_n       = sum;
            cnt_n       = MCW'(1);
            min_valid_n = 1'b1;
          end else if ((sum == MinCost) && (MatchCount != {MCW{1'b1}})) begin
            cnt_n = MatchCount + MCW'(1);
          end
        end
        pruned_n = 1'b0;
        if (last_perm) begin
          state_n = DONE;
        end else begin
          perm_n  = perm_adv;
          k_n     = '0;
          sum_n   = '0;
          state_n = SCAN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs derived from next-state values).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      perm       <= '0;
      k          <= '0;
      sum        <= '0;
      min_valid  <= 1'b0;
      pruned     <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
      W          <= '0;
      J          <= '0;
      BUSY       <= 1'b0;
      Valid      <= 1'b0;
    end else begin
      state      <= state_n;
      perm       <= perm_n;
      k          <= k_n;
      sum        <= sum_n;
      min_valid  <= min_valid_n;
      pruned     <= pruned_n;
      MinCost    <= min_n;
      MatchCount <= cnt_n;
      W          <= (state_n == SCAN) ? k_n : '0;
      J          <= (state_n == SCAN) ? perm_n[k_n] : '0;
      BUSY       <= (state_n == SCAN) || (state_n == NEXT);
      Valid      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_jam_search.sv
// Scoreboard bench for jam_search: instance A (N=4, MCW=16) and instance B
// (N=6, MCW=4, exercises count saturation). Expected results come from a
// brute-force model that enumerates all N^N index tuples and keeps the
// permutations; a monitor compares on every rising Valid.
module tb_jam_search;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  always #5 clk = ~clk;

  logic [1:0]  wa, ja;
  logic [6:0]  cost_a;
  logic        busy_a, valid_a;
  logic [15:0] mc_a;
  logic [8:0]  min_a;

  logic [2:0]  wb, jb;
  logic [6:0]  cost_b;
  logic        busy_b, valid_b;
  logic [3:0]  mc_b;
  logic [9:0]  min_b;

  int unsigned ma [4][4];
  int unsigned mb [6][6];

  assign cost_a = 7'(ma[wa][ja]);
  assign cost_b = 7'(mb[wb][jb]);

  jam_search #(.N(4), .CW(7), .MCW(16)) dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .W(wa), .J(ja), .Cost(cost_a),
    .BUSY(busy_a), .MatchCount(mc_a), .MinCost(min_a), .Valid(valid_a));

  jam_search #(.N(6), .CW(7), .MCW(4)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .W(wb), .J(jb), .Cost(cost_b),
    .BUSY(busy_b), .MatchCount(mc_b), .MinCost(min_b), .Valid(valid_b));

  typedef struct {
    int unsigned mn;
    int unsigned cnt;
    int unsigned cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  localparam int unsigned CYC_A = 24 * 5;   // 4! * (4+1)
  localparam int unsigned CYC_B = 720 * 7;  // 6! * (6+1)

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Brute force over all index tuples; keep only those that are permutations.
  function automatic void model(input bit sel, output int unsigned mn, output int unsigned cnt);
    int unsigned n, cap, total, v, used, s, j;
    bit ok;
    n     = sel ? 6 : 4;
    cap   = sel ? 15 : 65535;
    total = 1;
    for (int i = 0; i < int'(n); i++) total = total * n;
    mn  = 32'hFFFF_FFFF;
    cnt = 0;
    for (int unsigned t = 0; t < total; t++) begin
      v = t; used = 0; s = 0; ok = 1'b1;
      for (int w = 0; w < int'(n); w++) begin
        j = v % n;
        v = v / n;
        if (used[j]) ok = 1'b0;
        used = used | (32'd1 << j);
        s = s + (sel ? mb[w][j] : ma[w][j]);
      end
      if (ok) begin
        if (s < mn) begin
          mn = s;
          cnt = 1;
        end else if (s == mn && cnt < cap) begin
          cnt++;
        end
      end
    end
  endfunction

  task automatic launch_a(input int unsigned mn, input int unsigned cnt, input int hold);
    qa.push_back('{mn: mn, cnt: cnt, cyc: CYC_A});
    @(negedge clk) start_a = 1'b1;
    repeat (hold) @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic launch_a_model();
    int unsigned mn, cnt;
    model(1'b0, mn, cnt);
    launch_a(mn, cnt, 1);
  endtask

  task automatic launch_b(input int unsigned mn, input int unsigned cnt);
    qb.push_back('{mn: mn, cnt: cnt, cyc: CYC_B});
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (!valid_a && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("a_valid_reached", 32'(valid_a), 1);
  endtask

  task automatic wait_valid_b();
    int n = 0;
    while (!valid_b && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("b_valid_reached", 32'(valid_b), 1);
  endtask

  task automatic fill_a(input int unsigned hi);
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++) ma[w][j] = $urandom_range(hi, 0);
  endtask

  // Monitor A: count BUSY cycles, compare on rising Valid.
  int unsigned cyc_a;
  bit vd_a;
  always @(negedge clk) begin
    if (!rst) begin
      cyc_a = 0;
      vd_a  = 1'b0;
    end else begin
      if (busy_a) cyc_a++;
      if (valid_a && !vd_a) begin
        if (qa.size() == 0) begin
          check("a_unexpected_valid", 1, 0);
        end else begin
          ea = qa.pop_front();
          check("a_min_cost", 32'(min_a), ea.mn);
          check("a_match_count", 32'(mc_a), ea.cnt);
`ifdef JAM_PRUNE_EN
          check("a_cycles_within_bound", 32'(cyc_a <= ea.cyc), 1);
`else
          check("a_cycles", cyc_a, ea.cyc);
`endif
        end
        cyc_a = 0;
      end
      vd_a = valid_a;
    end
  end

  // Monitor B.
  int unsigned cyc_b;
  bit vd_b;
  always @(negedge clk) begin
    if (!rst) begin
      cyc_b = 0;
      vd_b  = 1'b0;
    end else begin
      if (busy_b) cyc_b++;
      if (valid_b && !vd_b) begin
        if (qb.size() == 0) begin
          check("b_unexpected_valid", 1, 0);
        end else begin
          eb = qb.pop_front();
          check("b_min_cost", 32'(min_b), eb.mn);
          check("b_match_count", 32'(mc_b), eb.cnt);
`ifdef JAM_PRUNE_EN
          check("b_cycles_within_bound", 32'(cyc_b <= eb.cyc), 1);
`else
          check("b_cycles", cyc_b, eb.cyc);
`endif
        end
        cyc_b = 0;
      end
      vd_b = valid_b;
    end
  end

  task automatic check_a_zero(input string tag);
    check({tag, "_W"}, 32'(wa), 0);
    check({tag, "_J"}, 32'(ja), 0);
    check({tag, "_BUSY"}, 32'(busy_a), 0);
    check({tag, "_MatchCount"}, 32'(mc_a), 0);
    check({tag, "_MinCost"}, 32'(min_a), 0);
    check({tag, "_Valid"}, 32'(valid_a), 0);
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) ma[w][j] = 0;
    for (int w = 0; w < 6; w++) for (int j = 0; j < 6; j++) mb[w][j] = 0;
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // All-zero costs: every permutation ties.
    launch_a(0, 24, 1);
    wait_valid_a();

    // Diagonal zero, others 5: only the identity reaches 0.
    for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) ma[w][j] = (w == j) ? 0 : 5;
    launch_a(0, 1, 1);
    wait_valid_a();

    // Cost = W+J: every permutation sums to 12.
    for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) ma[w][j] = w + j;
    launch_a(12, 24, 1);
    wait_valid_a();

    // Random matrices: wide range and narrow range (ties).
    for (int r = 0; r < 8; r++) begin
      fill_a((r < 4) ? 127 : 3);
      launch_a_model();
      wait_valid_a();
    end

    // START held from DONE well into SCAN: single restart, Valid drops on the sampling edge.
    fill_a(127);
    begin
      int unsigned mn, cnt;
      model(1'b0, mn, cnt);
      qa.push_back('{mn: mn, cnt: cnt, cyc: CYC_A});
    end
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1;
    check("a_valid_drop_on_start", 32'(valid_a), 0);
    check("a_busy_after_start", 32'(busy_a), 1);
    repeat (30) @(negedge clk);
    start_a = 1'b0;
    wait_valid_a();

    // Reset pulse mid-SCAN, then a clean rerun of the same matrix.
    fill_a(15);
    launch_a_model();
    repeat (7) @(negedge clk);
    rst = 1'b0;
    qa.delete();
    #1;
    check_a_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_a_zero("post_reset");
    launch_a_model();
    wait_valid_a();

    // Instance B: all 127 (count saturates at 15), then random 0..1.
    for (int w = 0; w < 6; w++) for (int j = 0; j < 6; j++) mb[w][j] = 127;
    launch_b(762, 15);
    wait_valid_b();
    for (int w = 0; w < 6; w++) for (int j = 0; j < 6; j++) mb[w][j] = $urandom_range(1, 0);
    begin
      int unsigned mn, cnt;
      model(1'b1, mn, cnt);
      launch_b(mn, cnt);
    end
    wait_valid_b();

    repeat (2) @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
